// File: rtl/mult_pkg.sv
// mult_pkg: shared constants, accumulate-op encodings and the stage-1
// payload struct for the multiplier back end (mult_stage_1).
package mult_pkg;

    localparam int PSUM_W     = 42;   // width of one weighted partial sum
    localparam int PSUM_N     = 4;    // partial sums; sum i has weight 2^(8*i)
    localparam int PSUM_SHIFT = 8;    // weight step between adjacent sums
    localparam int PROD_W     = 64;   // product width
    // One pair-sum: 42-bit sum plus a sum shifted by 8, plus the carry bit.
    localparam int PAIR_W     = PSUM_W + PSUM_SHIFT + 1;

    localparam logic [1:0] MULT_ACC_NONE = 2'b00;
    localparam logic [1:0] MULT_ACC_ADD  = 2'b01;
    localparam logic [1:0] MULT_ACC_SUB  = 2'b10;

    typedef struct packed {
        logic [PAIR_W-1:0] p01;
        logic [PAIR_W-1:0] p23;
        logic              neg;
        logic [1:0]        acc_op;
        logic [PROD_W-1:0] hilo;
    } s1_payload_t;

endpackage

// File: rtl/mult_pipe_ctrl.sv
// mult_pipe_ctrl: valid/ready control for the two registered stages of
// mult_stage_1. Produces the per-stage load enables and handles flush.
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop everything in flight (and any offered input)
//   in_valid/in_ready   upstream handshake
//   out_valid/out_ready downstream handshake
//   s1_load/s2_load     data-register enables for S1 / S2
module mult_pipe_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic s1_load,
    output logic s2_load
);

    logic [2:1] vld_pipe;   // [1] = S1 valid, [2] = S2 valid
    logic       advance1;
    logic       advance2;

    assign advance2  = ~vld_pipe[2] | out_ready;
    assign advance1  = ~vld_pipe[1] | advance2;
    assign in_ready  = advance1;
    assign out_valid = vld_pipe[2];

    // Data registers only move when a real operation lands in them; flush
    // leaves them untouched.
    assign s1_load = in_valid    & advance1 & ~flush;
    assign s2_load = vld_pipe[1] & advance2 & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            if (advance2) vld_pipe[2] <= vld_pipe[1];
            if (advance1) vld_pipe[1] <= in_valid;
        end
    end

endmodule

// File: rtl/mult_stage_1.sv
// mult_stage_1: back end of the two-part integer multiplier. Reduces four
// 42-bit weighted partial sums to a 64-bit product over two registered
// stages and presents it as HI/LO.
//   clk, rst_n           clock, synchronous active-low reset
//   flush                discard in-flight operations
//   in_valid/in_ready    input handshake
//   in_psum[167:0]       partial sum i at [42*i+41:42*i], weight 2^(8*i)
//   in_negate            two's-complement the final product
//   out_valid/out_ready  output handshake
//   out_hi, out_lo       product[63:32], product[31:0]
// Optional: MULT_STAGE_1_ACCUM_EN adds in_acc_op[1:0] and in_hilo[63:0]
// for MADD/MSUB style accumulation (result = hilo +/- product).
module mult_stage_1
    import mult_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [167:0] in_psum,
    input  logic         in_negate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_hi,
    output logic [31:0]  out_lo
`ifdef MULT_STAGE_1_ACCUM_EN
    ,
    input  logic [1:0]   in_acc_op,
    input  logic [63:0]  in_hilo
`endif
);

    logic              s1_load;
    logic              s2_load;
    logic [PSUM_W-1:0] psum [PSUM_N];
    s1_payload_t       s1_d;
    s1_payload_t       s1_q;
    logic [PROD_W-1:0] raw;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] result;
    logic [PROD_W-1:0] s2_q;

    mult_pipe_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s1_load   (s1_load),
        .s2_load   (s2_load)
    );

    for (genvar g = 0; g < PSUM_N; g++) begin : g_unpack
        assign psum[g] = in_psum[g*PSUM_W +: PSUM_W];
    end

    // S1: combine adjacent sums pairwise; each pair-sum is 51 bits wide.
    always_comb begin
        s1_d     = '0;
        s1_d.p01 = PAIR_W'(psum[0]) + (PAIR_W'(psum[1]) << PSUM_SHIFT);
        s1_d.p23 = PAIR_W'(psum[2]) + (PAIR_W'(psum[3]) << PSUM_SHIFT);
        s1_d.neg = in_negate;
`ifdef MULT_STAGE_1_ACCUM_EN
        s1_d.acc_op = in_acc_op;
        s1_d.hilo   = in_hilo;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       s1_q <= '0;
        else if (s1_load) s1_q <= s1_d;
    end

    // S2: final add; bits of p23 shifted past bit 63 are discarded.
    always_comb begin
        raw  = PROD_W'(s1_q.p01) + (PROD_W'(s1_q.p23) << (2*PSUM_SHIFT));
        prod = s1_q.neg ? (~raw + 64'd1) : raw;
    end

`ifdef MULT_STAGE_1_ACCUM_EN
    always_comb begin
        case (s1_q.acc_op)
            MULT_ACC_ADD: result = s1_q.hilo + prod;
            MULT_ACC_SUB: result = s1_q.hilo - prod;
            default:      result = prod;   // plain and reserved encoding
        endcase
    end
`else
    assign result = prod;
    // acc_op/hilo exist in the shared payload but are idle in this build.
    logic unused_acc;
    assign unused_acc = ^{s1_q.acc_op, s1_q.hilo};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)       s2_q <= '0;
        else if (s2_load) s2_q <= result;
    end

    assign out_hi = s2_q[63:32];
    assign out_lo = s2_q[31:0];

endmodule

// File: tb/tb_mult_stage_1.sv
// tb_mult_stage_1: directed-vector bench for mult_stage_1. Partial sums are
// built as a * b_byte[i] (weight 2^(8*i)); expected products are constants.
module tb_mult_stage_1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [167:0] in_psum;
    logic         in_negate;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_hi;
    logic [31:0]  out_lo;
`ifdef MULT_STAGE_1_ACCUM_EN
    logic [1:0]   in_acc_op;
    logic [63:0]  in_hilo;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_stage_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .in_negate (in_negate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo)
`ifdef MULT_STAGE_1_ACCUM_EN
        ,
        .in_acc_op (in_acc_op),
        .in_hilo   (in_hilo)
`endif
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h want 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [167:0] mk_psum(input logic [31:0] a, input logic [31:0] b);
        logic [167:0] p;
        logic [7:0]   bb;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            bb = b[8*i +: 8];
            p[42*i +: 42] = 42'(a) * 42'(bb);
        end
        return p;
    endfunction

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic neg);
        in_valid  = 1'b1;
        in_psum   = mk_psum(a, b);
        in_negate = neg;
    endtask

    // One isolated operation: check not-ready-yet after 1 edge, result after 2.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic neg, input logic [63:0] exp);
        @(negedge clk);
        set_op(a, b, neg);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        expect_eq({tag, "_lat2"}, 64'(out_valid), 64'd1);
        expect_eq({tag, "_res"}, {out_hi, out_lo}, exp);
    endtask

    // Two ops in flight, a third offered, then kill with flush or reset.
    task automatic kill_test(input string tag, input logic use_reset);
        logic seen;
        @(negedge clk);
        out_ready = 1'b0;
        set_op(32'd3, 32'd5, 1'b0);
        @(negedge clk);
        set_op(32'd7, 32'd3, 1'b0);
        @(negedge clk);
        set_op(32'h100, 32'h0101, 1'b0);
        if (use_reset) rst_n = 1'b0;
        else           flush = 1'b1;
        @(negedge clk);
        rst_n    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_eq({tag, "_vld"}, 64'(out_valid), 64'd0);
        expect_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
        // Reset clears the data; flush leaves the S2 register holding 3*5.
        expect_eq({tag, "_data"}, {out_hi, out_lo}, use_reset ? 64'd0 : 64'd15);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        expect_eq({tag, "_ghost"}, 64'(seen), 64'd0);
    endtask

    initial begin : main
        logic [31:0] sa [4];
        logic [31:0] sb [4];
        logic [63:0] sexp [4];
        logic [63:0] exp_q [$];
        logic [63:0] held;
        logic        stalled;
        logic        saw_block;
        int          k;
        int          got_n;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_psum = '0;
        in_negate = 1'b0; out_ready = 1'b0;
`ifdef MULT_STAGE_1_ACCUM_EN
        in_acc_op = 2'b00; in_hilo = '0;
`endif
        repeat (3) @(negedge clk);
        expect_eq("rst_vld", 64'(out_valid), 64'd0);
        expect_eq("rst_data", {out_hi, out_lo}, 64'd0);
        expect_eq("rst_rdy", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        single("mul3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        single("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        single("neg7x3", 32'd7, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        single("neg0", 32'd0, 32'd9, 1'b1, 64'd0);

        // Stream of 4 with out_ready low for cycles 3..5.
        sa   = '{32'h100,    32'd3,  32'h1_0000,     32'd2};
        sb   = '{32'h0101,   32'd5,  32'h1_0000,     32'h0100_0000};
        sexp = '{64'h1_0100, 64'hF,  64'h1_0000_0000, 64'h200_0000};
        k = 0; got_n = 0; stalled = 1'b0; saw_block = 1'b0; held = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (stalled) expect_eq($sformatf("stall_hold%0d", cyc), {out_hi, out_lo}, held);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (k < 4) set_op(sa[k], sb[k], 1'b0);
            else       in_valid = 1'b0;
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) begin
                exp_q.push_back(sexp[k]);
                k++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) expect_eq("stream_extra", 64'(out_valid), 64'd0);
                else expect_eq($sformatf("stream_res%0d", got_n), {out_hi, out_lo}, exp_q.pop_front());
                got_n++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_hi, out_lo};
        end
        expect_eq("stream_count", 64'(got_n), 64'd4);
        expect_eq("stream_block", 64'(saw_block), 64'd1);

        kill_test("flush", 1'b0);
        kill_test("rstmid", 1'b1);

`ifdef MULT_STAGE_1_ACCUM_EN
        @(negedge clk);
        set_op(32'd2, 32'd3, 1'b0);
        in_acc_op = 2'b10;
        in_hilo   = 64'h0000_0001_0000_0000;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_acc_op = 2'b00; in_hilo = '0;
        @(negedge clk);
        expect_eq("msub_vld", 64'(out_valid), 64'd1);
        expect_eq("msub_res", {out_hi, out_lo}, 64'h0000_0000_FFFF_FFFA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
